// File: rtl/SystemPeripheral_Pkg.sv
// SystemPeripheral_Pkg
// Shared types and constants for the system peripheral bus, including the
// register map and arbitration result type of the external interrupt
// controller (ext_int_ctrl_plic).
//
// Contents:
//   sys_peripheral_t  - shared write address/data and read address (byte offsets)
//   sel_t             - per-block write/read select
//   eic_best_t        - arbitration result: source index, priority, valid
//   EIC_*             - interrupt controller register byte offsets
//   CUSTOM_CODE_BEGIN - first custom interrupt cause code
//   eic_prio_addr()   - byte offset of PRIORITY[idx]
package SystemPeripheral_Pkg;

    localparam int CUSTOM_CODE_BEGIN = 16;

    // Source index width covers the 32-source maximum; priority field is
    // wide enough for any PRIO_W up to 8.
    localparam int EIC_ID_W       = 5;
    localparam int EIC_PRIO_W_MAX = 8;

    localparam logic [31:0] EIC_ENABLE    = 32'h00;
    localparam logic [31:0] EIC_PENDING   = 32'h04;
    localparam logic [31:0] EIC_TRIGGER   = 32'h08;
    localparam logic [31:0] EIC_THRESHOLD = 32'h0C;
    localparam logic [31:0] EIC_CLAIM     = 32'h10;
    localparam logic [31:0] EIC_INSERVICE = 32'h14;
    localparam logic [31:0] EIC_PRIO_BASE = 32'h40;

    typedef struct packed {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
    } sys_peripheral_t;

    typedef struct packed {
        logic wen;
        logic ren;
    } sel_t;

    typedef struct packed {
        logic [EIC_ID_W-1:0]       id;
        logic [EIC_PRIO_W_MAX-1:0] prio;
        logic                      valid;
    } eic_best_t;

    function automatic logic [31:0] eic_prio_addr(input int idx);
        return EIC_PRIO_BASE + (32'(idx) << 2);
    endfunction

endpackage

// File: rtl/ext_int_arbiter.sv
// ext_int_arbiter
// Combinational priority arbiter for the external interrupt controller.
// Picks the eligible source with the highest priority; on equal priority
// the lowest index wins.
//
// Parameters: INT_NUM (1..32 sources), PRIO_W (priority width, <= 8)
// Ports:
//   eligible - per-source eligibility mask
//   prio     - per-source priority array
//   best     - winning source (id = index, prio, valid); all zero if none
module ext_int_arbiter
    import SystemPeripheral_Pkg::*;
#(
    parameter int INT_NUM = 32,
    parameter int PRIO_W  = 3
) (
    input  logic [INT_NUM-1:0]             eligible,
    input  logic [INT_NUM-1:0][PRIO_W-1:0] prio,
    output eic_best_t                      best
);

    // Leaf count rounded up to a power of two so the tree is complete.
    localparam int LEAVES = (INT_NUM <= 1) ? 1 : (1 << $clog2(INT_NUM));

    // Heap-ordered comparison tree: node n has children 2n+1 (lower
    // indices) and 2n+2 (higher indices). The right child only wins on a
    // strictly higher priority, which is what gives lowest-index tie-break.
    always_comb begin
        eic_best_t node [2*LEAVES-1];
        for (int n = 0; n < 2*LEAVES-1; n++) begin
            node[n] = '0;
        end
        for (int i = 0; i < INT_NUM; i++) begin
            node[LEAVES-1+i].id    = EIC_ID_W'(i);
            node[LEAVES-1+i].prio  = EIC_PRIO_W_MAX'(prio[i]);
            node[LEAVES-1+i].valid = eligible[i];
        end
        for (int n = LEAVES-2; n >= 0; n--) begin
            if (node[2*n+2].valid &&
                (!node[2*n+1].valid || (node[2*n+2].prio > node[2*n+1].prio))) begin
                node[n] = node[2*n+2];
            end else begin
                node[n] = node[2*n+1];
            end
        end
        // An idle controller reports id 0 rather than a stray leaf index.
        best = node[0].valid ? node[0] : '0;
    end

endmodule

// File: rtl/ext_int_ctrl_plic.sv
// ext_int_ctrl_plic
// Priority-based external interrupt controller on the system peripheral bus.
// Each source has a level/edge gateway with pending and in-service bits, a
// priority, and an enable. A global threshold gates the core interrupt, and
// a single CLAIM/COMPLETE register implements the claim handshake.
//
// Optional build macro: EXT_INT_SYNC_EN adds a 2-flop synchroniser on every
// irq_source bit (edge detection then uses the synchronised signal).
//
// Parameters: INT_NUM (1..32 sources, ID = index + 1), PRIO_W (<= 8)
// Ports:
//   hb_clk          - bus/system clock
//   rst             - asynchronous active-high reset
//   sys_share       - shared bus waddr/wdata/raddr (byte offsets)
//   sel             - wen/ren select for this block
//   rdata           - registered read data, valid one cycle after sel.ren
//   irq_source      - raw interrupt requests
//   custom_int_code - 16 + index of the current best source
//   mextern_int     - machine external interrupt request to the core
module ext_int_ctrl_plic
    import SystemPeripheral_Pkg::*;
#(
    parameter int INT_NUM = 32,
    parameter int PRIO_W  = 3
) (
    input  logic            hb_clk,
    input  logic            rst,
    input  sys_peripheral_t sys_share,
    input  sel_t            sel,
    output logic [31:0]     rdata,
    input  logic [INT_NUM-1:0] irq_source,
    output logic [30:0]     custom_int_code,
    output logic            mextern_int
);

    logic [INT_NUM-1:0]             enable;
    logic [INT_NUM-1:0]             trigger;
    logic [PRIO_W-1:0]              threshold;
    logic [INT_NUM-1:0][PRIO_W-1:0] prio;

    logic [INT_NUM-1:0] pending;
    logic [INT_NUM-1:0] in_service;
    logic [INT_NUM-1:0] src;
    logic [INT_NUM-1:0] src_prev;

    logic [EIC_ID_W-1:0] best_id;
    logic                best_valid;
    eic_best_t           arb_best;

    logic [INT_NUM-1:0] prio_nz;
    logic [INT_NUM-1:0] eligible;
    logic [INT_NUM-1:0] edge_set;
    logic [INT_NUM-1:0] claim_mask;
    logic [INT_NUM-1:0] complete_mask;
    logic [INT_NUM-1:0] w1c_mask;
    logic [INT_NUM-1:0] pending_next;
    logic [INT_NUM-1:0] in_service_next;

    logic        wr_enable, wr_pending, wr_trigger, wr_threshold, wr_complete;
    logic        rd_claim, claim_live, claim_fire;
    logic [31:0] elig32;
    logic [31:0] claim_value;
    logic [31:0] rd_data;

`ifdef EXT_INT_SYNC_EN
    logic [INT_NUM-1:0] sync_q1;
    logic [INT_NUM-1:0] sync_q2;

    // Two-flop synchroniser for sources from other clock domains.
    always_ff @(posedge hb_clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_source;
            sync_q2 <= sync_q1;
        end
    end

    assign src = sync_q2;
`else
    assign src = irq_source;
`endif

    assign wr_enable    = sel.wen && (sys_share.waddr == EIC_ENABLE);
    assign wr_pending   = sel.wen && (sys_share.waddr == EIC_PENDING);
    assign wr_trigger   = sel.wen && (sys_share.waddr == EIC_TRIGGER);
    assign wr_threshold = sel.wen && (sys_share.waddr == EIC_THRESHOLD);
    assign wr_complete  = sel.wen && (sys_share.waddr == EIC_CLAIM);
    assign rd_claim     = sel.ren && (sys_share.raddr == EIC_CLAIM);

    assign eligible = pending & enable & ~in_service & prio_nz;

    // The registered best is one cycle old, so re-check it against live
    // state; this stops a back-to-back claim from returning a duplicate ID.
    assign elig32      = 32'(eligible);
    assign claim_live  = best_valid && elig32[best_id];
    assign claim_fire  = rd_claim && claim_live;
    assign claim_value = claim_live ? (32'(best_id) + 32'd1) : 32'd0;

    assign edge_set = trigger & enable & src & ~src_prev;
    assign w1c_mask = wr_pending ? (sys_share.wdata[INT_NUM-1:0] & trigger) : '0;

    // Per-source decode of claim and complete. Completing an ID that is not
    // in service (or out of range) matches no source and does nothing.
    always_comb begin
        prio_nz       = '0;
        claim_mask    = '0;
        complete_mask = '0;
        for (int i = 0; i < INT_NUM; i++) begin
            prio_nz[i]       = |prio[i];
            claim_mask[i]    = claim_fire && (best_id == EIC_ID_W'(i));
            complete_mask[i] = wr_complete && (sys_share.wdata == 32'(i + 1)) && in_service[i];
        end
    end

    // Edge sources: a new edge beats a same-cycle claim or W1C clear.
    // Level sources follow the line, suppressed while in service and on
    // the claim edge itself.
    assign pending_next = (trigger & ((pending & ~claim_mask & ~w1c_mask) | edge_set))
                        | (~trigger & src & enable & ~in_service & ~claim_mask);
    assign in_service_next = (in_service & ~complete_mask) | claim_mask;

    ext_int_arbiter #(
        .INT_NUM (INT_NUM),
        .PRIO_W  (PRIO_W)
    ) u_arbiter (
        .eligible (eligible),
        .prio     (prio),
        .best     (arb_best)
    );

    // Read mux; unmapped offsets fall through to zero.
    always_comb begin
        rd_data = '0;
        case (sys_share.raddr)
            EIC_ENABLE:    rd_data = 32'(enable);
            EIC_PENDING:   rd_data = 32'(pending);
            EIC_TRIGGER:   rd_data = 32'(trigger);
            EIC_THRESHOLD: rd_data = 32'(threshold);
            EIC_CLAIM:     rd_data = claim_value;
            EIC_INSERVICE: rd_data = 32'(in_service);
            default:       rd_data = '0;
        endcase
        for (int i = 0; i < INT_NUM; i++) begin
            if (sys_share.raddr == eic_prio_addr(i)) begin
                rd_data = 32'(prio[i]);
            end
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge hb_clk or posedge rst) begin
        if (rst) begin
            enable    <= '0;
            trigger   <= '0;
            threshold <= '0;
            prio      <= '0;
        end else begin
            if (wr_enable) begin
                enable <= sys_share.wdata[INT_NUM-1:0];
            end
            if (wr_trigger) begin
                trigger <= sys_share.wdata[INT_NUM-1:0];
            end
            if (wr_threshold) begin
                threshold <= sys_share.wdata[PRIO_W-1:0];
            end
            for (int i = 0; i < INT_NUM; i++) begin
                if (sel.wen && (sys_share.waddr == eic_prio_addr(i))) begin
                    prio[i] <= sys_share.wdata[PRIO_W-1:0];
                end
            end
        end
    end

    // Gateway state per source.
    always_ff @(posedge hb_clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            in_service <= '0;
            src_prev   <= '0;
        end else begin
            pending    <= pending_next;
            in_service <= in_service_next;
            src_prev   <= src;
        end
    end

    // Arbitration result and core-facing outputs are loaded together from
    // the arbiter so the interrupt appears one cycle after pending.
    always_ff @(posedge hb_clk or posedge rst) begin
        if (rst) begin
            best_id         <= '0;
            best_valid      <= 1'b0;
            mextern_int     <= 1'b0;
            custom_int_code <= 31'(CUSTOM_CODE_BEGIN);
        end else begin
            best_id         <= arb_best.id;
            best_valid      <= arb_best.valid;
            mextern_int     <= arb_best.valid && (arb_best.prio > EIC_PRIO_W_MAX'(threshold));
            custom_int_code <= 31'(CUSTOM_CODE_BEGIN) + 31'(arb_best.id);
        end
    end

    // Registered read data; holds between reads.
    always_ff @(posedge hb_clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (sel.ren) begin
            rdata <= rd_data;
        end
    end

endmodule

// File: tb/tb_ext_int_ctrl_plic.sv
// tb_ext_int_ctrl_plic
// Directed self-checking bench for ext_int_ctrl_plic: reset state, register
// access, level and edge gateways, priority/tie arbitration, threshold,
// back-to-back claims, same-cycle collisions and asynchronous reset.
module tb_ext_int_ctrl_plic;
    import SystemPeripheral_Pkg::*;

    localparam int INT_NUM = 32;
    localparam int PRIO_W  = 3;
`ifdef EXT_INT_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic               hb_clk = 1'b0;
    logic               rst;
    sys_peripheral_t    sys_share;
    sel_t               sel;
    logic [31:0]        rdata;
    logic [INT_NUM-1:0] irq_source;
    logic [30:0]        custom_int_code;
    logic               mextern_int;

    int vectors     = 0;
    int miscompares = 0;

    always #5 hb_clk = ~hb_clk;

    ext_int_ctrl_plic #(
        .INT_NUM (INT_NUM),
        .PRIO_W  (PRIO_W)
    ) dut (
        .hb_clk          (hb_clk),
        .rst             (rst),
        .sys_share       (sys_share),
        .sel             (sel),
        .rdata           (rdata),
        .irq_source      (irq_source),
        .custom_int_code (custom_int_code),
        .mextern_int     (mextern_int)
    );

    // Advance n active edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge hb_clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge hb_clk);
        sys_share.waddr = addr;
        sys_share.wdata = data;
        sel.wen = 1'b1;
        @(posedge hb_clk);
        #1;
        sel.wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge hb_clk);
        sys_share.raddr = addr;
        sel.ren = 1'b1;
        @(posedge hb_clk);
        #1;
        sel.ren = 1'b0;
        data = rdata;
    endtask

    task automatic apply_reset();
        @(negedge hb_clk);
        rst        = 1'b1;
        irq_source = '0;
        sel        = '0;
        sys_share  = '0;
        @(negedge hb_clk);
        rst = 1'b0;
    endtask

    // Reset values of outputs and registers.
    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1; irq_source = '0; sel = '0; sys_share = '0;
        #12;
        vectors++;
        if (rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
        vectors++;
        if (mextern_int !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mextern: got %b want 0", mextern_int); end
        vectors++;
        if (custom_int_code !== 31'd16) begin miscompares++; $display("[TB] FAIL reset_code: got %0d want 16", custom_int_code); end
        @(negedge hb_clk);
        rst = 1'b0;
        bus_read(EIC_CLAIM, r);
        vectors++;
        if (r !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_claim: got %0d want 0", r); end
    endtask

    // Read/write behaviour of the register map including unmapped offsets.
    task automatic test_registers();
        logic [31:0] r;
        apply_reset();
        bus_write(EIC_ENABLE, 32'hA5A5_0001);
        bus_read(EIC_ENABLE, r);
        vectors++;
        if (r !== 32'hA5A5_0001) begin miscompares++; $display("[TB] FAIL reg_enable: got %h want a5a50001", r); end
        bus_write(EIC_THRESHOLD, 32'hFF);
        bus_read(EIC_THRESHOLD, r);
        vectors++;
        if (r !== 32'd7) begin miscompares++; $display("[TB] FAIL reg_threshold: got %h want 7", r); end
        bus_write(32'hBC, 32'h6);
        bus_read(32'hBC, r);
        vectors++;
        if (r !== 32'd6) begin miscompares++; $display("[TB] FAIL reg_prio31: got %h want 6", r); end
        bus_write(32'hC0, 32'h5);
        bus_read(32'hC0, r);
        vectors++;
        if (r !== 32'd0) begin miscompares++; $display("[TB] FAIL reg_unmapped_c0: got %h want 0", r); end
        bus_write(EIC_INSERVICE, 32'hFF);
        bus_read(EIC_INSERVICE, r);
        vectors++;
        if (r !== 32'd0) begin miscompares++; $display("[TB] FAIL reg_inservice_ro: got %h want 0", r); end
    endtask

    // Level source 3: latency, code, claim, drop, complete-and-reassert.
    task automatic test_level_basic();
        logic [31:0] r;
        apply_reset();
        bus_write(32'h4C, 32'd2);
        bus_write(EIC_THRESHOLD, 32'd0);
        bus_write(EIC_ENABLE, 32'h8);
        @(negedge hb_clk);
        irq_source[3] = 1'b1;
        tick(LAT - 1);
        vectors++;
        if (mextern_int !== 1'b0) begin miscompares++; $display("[TB] FAIL level_early: got %b want 0", mextern_int); end
        tick(1);
        vectors++;
        if (mextern_int !== 1'b1) begin miscompares++; $display("[TB] FAIL level_latency: got %b want 1", mextern_int); end
        vectors++;
        if (custom_int_code !== 31'd19) begin miscompares++; $display("[TB] FAIL level_code: got %0d want 19", custom_int_code); end
        bus_read(EIC_CLAIM, r);
        vectors++;
        if (r !== 32'd4) begin miscompares++; $display("[TB] FAIL level_claim: got %0d want 4", r); end
        tick(1);
        vectors++;
        if (mextern_int !== 1'b0) begin miscompares++; $display("[TB] FAIL level_drop: got %b want 0", mextern_int); end
        vectors++;
        if (custom_int_code !== 31'd16) begin miscompares++; $display("[TB] FAIL level_code_idle: got %0d want 16", custom_int_code); end
        bus_read(EIC_INSERVICE, r);
        vectors++;
        if (r !== 32'h8) begin miscompares++; $display("[TB] FAIL level_inservice: got %h want 8", r); end
        bus_write(EIC_CLAIM, 32'd4);
        tick(2);
        vectors++;
        if (mextern_int !== 1'b1) begin miscompares++; $display("[TB] FAIL level_reassert: got %b want 1", mextern_int); end
    endtask

    // IDs 2 and 6 at priority 3, ID 3 at priority 5: claim order 3, 2, 6, 0.
    task automatic test_priority_tie();
        logic [31:0] r;
        logic [31:0] expect_ids [4];
        expect_ids[0] = 32'd3; expect_ids[1] = 32'd2; expect_ids[2] = 32'd6; expect_ids[3] = 32'd0;
        apply_reset();
        bus_write(32'h44, 32'd3);
        bus_write(32'h54, 32'd3);
        bus_write(32'h48, 32'd5);
        bus_write(EIC_ENABLE, 32'h26);
        @(negedge hb_clk);
        irq_source = 32'h26;
        tick(LAT + 1);
        for (int k = 0; k < 4; k++) begin
            bus_read(EIC_CLAIM, r);
            vectors++;
            if (r !== expect_ids[k]) begin miscompares++; $display("[TB] FAIL prio_claim%0d: got %0d want %0d", k, r, expect_ids[k]); end
            tick(1);
        end
        vectors++;
        if (mextern_int !== 1'b0) begin miscompares++; $display("[TB] FAIL prio_all_claimed: got %b want 0", mextern_int); end
    endtask

    // Two claims on consecutive cycles never return the same ID.
    task automatic test_back_to_back();
        logic [31:0] r1, r2, r3;
        logic [31:0] want3;
        apply_reset();
        bus_write(32'h40, 32'd4);
        bus_write(32'h4C, 32'd2);
        bus_write(EIC_ENABLE, 32'h9);
        @(negedge hb_clk);
        irq_source = 32'h9;
        tick(LAT + 1);
        bus_read(EIC_CLAIM, r1);
        bus_read(EIC_CLAIM, r2);
        vectors++;
        if (r1 !== 32'd1) begin miscompares++; $display("[TB] FAIL b2b_first: got %0d want 1", r1); end
        vectors++;
        if (!(r2 === 32'd0 || r2 === 32'd4)) begin miscompares++; $display("[TB] FAIL b2b_second: got %0d want 0 or 4", r2); end
        want3 = (r2 === 32'd0) ? 32'd4 : 32'd0;
        tick(1);
        bus_read(EIC_CLAIM, r3);
        vectors++;
        if (r3 !== want3) begin miscompares++; $display("[TB] FAIL b2b_third: got %0d want %0d", r3, want3); end
    endtask

    // Priority equal to threshold is masked from the core but still claimable.
    task automatic test_threshold();
        logic [31:0] r;
        apply_reset();
        bus_write(32'h40, 32'd2);
        bus_write(EIC_THRESHOLD, 32'd2);
        bus_write(EIC_ENABLE, 32'h1);
        @(negedge hb_clk);
        irq_source[0] = 1'b1;
        tick(LAT + 1);
        vectors++;
        if (mextern_int !== 1'b0) begin miscompares++; $display("[TB] FAIL thr_equal: got %b want 0", mextern_int); end
        vectors++;
        if (custom_int_code !== 31'd16) begin miscompares++; $display("[TB] FAIL thr_code: got %0d want 16", custom_int_code); end
        bus_read(EIC_CLAIM, r);
        vectors++;
        if (r !== 32'd1) begin miscompares++; $display("[TB] FAIL thr_claim: got %0d want 1", r); end
        bus_write(EIC_CLAIM, 32'd1);
        bus_write(EIC_THRESHOLD, 32'd1);
        tick(3);
        vectors++;
        if (mextern_int !== 1'b1) begin miscompares++; $display("[TB] FAIL thr_below: got %b want 1", mextern_int); end
        bus_write(32'h40, 32'd0);
        tick(3);
        vectors++;
        if (mextern_int !== 1'b0) begin miscompares++; $display("[TB] FAIL thr_prio0_irq: got %b want 0", mextern_int); end
        bus_read(EIC_CLAIM, r);
        vectors++;
        if (r !== 32'd0) begin miscompares++; $display("[TB] FAIL thr_prio0_claim: got %0d want 0", r); end
    endtask

    // Edge source 0: capture, re-arm while in service, disable masking, W1C.
    task automatic test_edge_capture();
        logic [31:0] r;
        apply_reset();
        bus_write(EIC_TRIGGER, 32'h1);
        bus_write(32'h40, 32'd1);
        bus_write(EIC_ENABLE, 32'h1);
        @(negedge hb_clk); irq_source[0] = 1'b1;
        @(negedge hb_clk); irq_source[0] = 1'b0;
        tick(LAT + 1);
        vectors++;
        if (mextern_int !== 1'b1) begin miscompares++; $display("[TB] FAIL edge_irq: got %b want 1", mextern_int); end
        bus_read(EIC_CLAIM, r);
        vectors++;
        if (r !== 32'd1) begin miscompares++; $display("[TB] FAIL edge_claim: got %0d want 1", r); end
        @(negedge hb_clk); irq_source[0] = 1'b1;
        @(negedge hb_clk); irq_source[0] = 1'b0;
        tick(LAT + 1);
        bus_read(EIC_PENDING, r);
        vectors++;
        if (r !== 32'd1) begin miscompares++; $display("[TB] FAIL edge_rearm_pending: got %h want 1", r); end
        vectors++;
        if (mextern_int !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_inservice_irq: got %b want 0", mextern_int); end
        bus_write(EIC_CLAIM, 32'd1);
        tick(2);
        vectors++;
        if (mextern_int !== 1'b1) begin miscompares++; $display("[TB] FAIL edge_complete_irq: got %b want 1", mextern_int); end
        bus_write(EIC_ENABLE, 32'h0);
        tick(2);
        vectors++;
        if (mextern_int !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_disabled_irq: got %b want 0", mextern_int); end
        bus_read(EIC_PENDING, r);
        vectors++;
        if (r !== 32'd1) begin miscompares++; $display("[TB] FAIL edge_disabled_pending: got %h want 1", r); end
        bus_write(EIC_ENABLE, 32'h1);
        bus_write(EIC_PENDING, 32'h1);
        tick(2);
        vectors++;
        if (mextern_int !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_w1c_irq: got %b want 0", mextern_int); end
        bus_read(EIC_PENDING, r);
        vectors++;
        if (r !== 32'd0) begin miscompares++; $display("[TB] FAIL edge_w1c_pending: got %h want 0", r); end
    endtask

    // Same-cycle edge+claim, invalid completes, and W1C+claim.
    task automatic test_collisions();
        logic [31:0] r;
        apply_reset();
        bus_write(EIC_TRIGGER, 32'h1);
        bus_write(32'h40, 32'd1);
        bus_write(EIC_ENABLE, 32'h1);
        @(negedge hb_clk); irq_source[0] = 1'b1;
        @(negedge hb_clk); irq_source[0] = 1'b0;
        tick(LAT + 1);
        @(negedge hb_clk);
        irq_source[0] = 1'b1;
        repeat (LAT - 2) @(negedge hb_clk);
        sys_share.raddr = EIC_CLAIM;
        sel.ren = 1'b1;
        @(posedge hb_clk);
        #1;
        sel.ren = 1'b0;
        r = rdata;
        vectors++;
        if (r !== 32'd1) begin miscompares++; $display("[TB] FAIL coll_edge_claim: got %0d want 1", r); end
        @(negedge hb_clk); irq_source[0] = 1'b0;
        bus_read(EIC_PENDING, r);
        vectors++;
        if (r !== 32'd1) begin miscompares++; $display("[TB] FAIL coll_edge_pending: got %h want 1", r); end
        bus_read(EIC_INSERVICE, r);
        vectors++;
        if (r !== 32'd1) begin miscompares++; $display("[TB] FAIL coll_edge_inservice: got %h want 1", r); end
        bus_write(EIC_CLAIM, 32'd40);
        bus_write(EIC_CLAIM, 32'd0);
        bus_write(EIC_CLAIM, 32'd2);
        bus_read(EIC_INSERVICE, r);
        vectors++;
        if (r !== 32'd1) begin miscompares++; $display("[TB] FAIL coll_bad_complete: got %h want 1", r); end
        bus_write(EIC_CLAIM, 32'd1);
        bus_read(EIC_INSERVICE, r);
        vectors++;
        if (r !== 32'd0) begin miscompares++; $display("[TB] FAIL coll_good_complete: got %h want 0", r); end
        tick(2);
        @(negedge hb_clk);
        sys_share.waddr = EIC_PENDING;
        sys_share.wdata = 32'h1;
        sel.wen = 1'b1;
        sys_share.raddr = EIC_CLAIM;
        sel.ren = 1'b1;
        @(posedge hb_clk);
        #1;
        sel.wen = 1'b0;
        sel.ren = 1'b0;
        r = rdata;
        vectors++;
        if (r !== 32'd1) begin miscompares++; $display("[TB] FAIL coll_w1c_claim: got %0d want 1", r); end
        bus_read(EIC_PENDING, r);
        vectors++;
        if (r !== 32'd0) begin miscompares++; $display("[TB] FAIL coll_w1c_pending: got %h want 0", r); end
        bus_read(EIC_INSERVICE, r);
        vectors++;
        if (r !== 32'd1) begin miscompares++; $display("[TB] FAIL coll_w1c_inservice: got %h want 1", r); end
    endtask

    // Reset asserted between edges clears outputs without a clock.
    task automatic test_async_reset();
        logic [31:0] r;
        apply_reset();
        bus_write(32'h40, 32'd1);
        bus_write(EIC_ENABLE, 32'h1);
        @(negedge hb_clk);
        irq_source[0] = 1'b1;
        tick(LAT + 1);
        bus_read(EIC_ENABLE, r);
        vectors++;
        if (mextern_int !== 1'b1 || r !== 32'd1) begin miscompares++; $display("[TB] FAIL arst_setup: got irq=%b rd=%h want irq=1 rd=1", mextern_int, r); end
        @(negedge hb_clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (mextern_int !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_mextern: got %b want 0", mextern_int); end
        vectors++;
        if (custom_int_code !== 31'd16) begin miscompares++; $display("[TB] FAIL arst_code: got %0d want 16", custom_int_code); end
        vectors++;
        if (rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL arst_rdata: got %h want 0", rdata); end
        @(negedge hb_clk);
        rst = 1'b0;
        irq_source = '0;
        bus_read(EIC_ENABLE, r);
        vectors++;
        if (r !== 32'd0) begin miscompares++; $display("[TB] FAIL arst_enable: got %h want 0", r); end
        bus_read(32'h40, r);
        vectors++;
        if (r !== 32'd0) begin miscompares++; $display("[TB] FAIL arst_prio0: got %h want 0", r); end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_level_basic();
        test_priority_tie();
        test_back_to_back();
        test_threshold();
        test_edge_capture();
        test_collisions();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run still active at time %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
